// File: rtl/nor3_response_checker.sv
// ============================================================================
// Module      : nor3_response_checker
// Description : Receive end of a 3-input NOR stimulus interface. Accepts a vector,
//               waits a settle time, samples the DUT output, compares it with
//               ~(a|b|c), counts passes and failures, tracks coverage of all eight
//               vectors and reports a verdict.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nor3_response_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8,
  parameter int STOP_ON_FAIL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [2:0]       vec,
  output logic             vec_ready,
  input  logic             dut_d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [7:0]       covered,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_vld
);

  // Settle counter must hold SETTLE_CYCLES; keep at least one bit when it is zero.
  localparam int C_SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [C_SET_W-1:0] C_SETTLE_INIT = C_SET_W'(SETTLE_CYCLES);
  localparam logic [C_SET_W-1:0] C_SETTLE_ONE  = C_SET_W'(1);
  localparam logic [CNT_W-1:0]   C_CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   C_CNT_ONE     = CNT_W'(1);
  localparam logic               C_HAS_SETTLE  = (SETTLE_CYCLES > 0);
  localparam logic               C_STOP        = (STOP_ON_FAIL != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [C_SET_W-1:0] cnt_q, cnt_d;
  logic [2:0]         vec_q, vec_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [7:0]         covered_q, covered_d;
  logic [2:0]         ff_vec_q, ff_vec_d;
  logic               ff_vld_q, ff_vld_d;

  logic               w_exp;
  logic               w_match;
  logic [7:0]         w_cov_upd;

  assign w_exp     = ~|vec_q;
  assign w_match   = (dut_d == w_exp);
  assign w_cov_upd = covered_q | (8'd1 << vec_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    covered_d  = covered_q;
    ff_vec_d   = ff_vec_q;
    ff_vld_d   = ff_vld_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // A fresh run starts with a clean scoreboard from either idle or done.
        if (start) begin
          state_d    = S_ARM;
          cnt_d      = '0;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          covered_d  = '0;
          ff_vec_d   = '0;
          ff_vld_d   = 1'b0;
        end
      end

      S_ARM: begin
        if (vec_valid) begin
          vec_d = vec;
          if (C_HAS_SETTLE) begin
            state_d = S_SETTLE;
            cnt_d   = C_SETTLE_INIT;
          end else begin
            state_d = S_SAMPLE;
          end
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q - C_SETTLE_ONE;
        if (cnt_q == C_SETTLE_ONE) begin
          state_d = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        if (w_match) begin
          if (pass_cnt_q != C_CNT_MAX) begin
            pass_cnt_d = pass_cnt_q + C_CNT_ONE;
          end
        end else begin
          if (fail_cnt_q != C_CNT_MAX) begin
            fail_cnt_d = fail_cnt_q + C_CNT_ONE;
          end
          if (!ff_vld_q) begin
            ff_vec_d = vec_q;
            ff_vld_d = 1'b1;
          end
        end
        covered_d = w_cov_upd;
        if ((w_cov_upd == 8'hFF) || (C_STOP && !w_match)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ARM;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      vec_q      <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      covered_q  <= '0;
      ff_vec_q   <= '0;
      ff_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      covered_q  <= covered_d;
      ff_vec_q   <= ff_vec_d;
      ff_vld_q   <= ff_vld_d;
    end
  end

  assign vec_ready      = (state_q == S_ARM);
  assign busy           = (state_q == S_ARM) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (fail_cnt_q == '0) && (covered_q == 8'hFF);
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign covered        = covered_q;
  assign first_fail_vec = ff_vec_q;
  assign first_fail_vld = ff_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_nor3_response_checker.sv
// ============================================================================
// Module      : tb_nor3_response_checker
// Description : Randomized self-checking bench for nor3_response_checker; four
//               instances cover default, long settle, zero settle with stop-on-fail,
//               and narrow saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nor3_response_checker;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      rst, start, vec_valid, dut_d;
  logic [N-1:0][2:0] vec;
  logic [N-1:0]      vec_ready, busy, done, pass, ff_vld;
  logic [N-1:0][7:0] pass_cnt, fail_cnt, covered;
  logic [N-1:0][2:0] ff_vec;
  logic [1:0]        pc3, fc3;

  assign pass_cnt[3] = {6'd0, pc3};
  assign fail_cnt[3] = {6'd0, fc3};

  nor3_response_checker #(.SETTLE_CYCLES(2), .CNT_W(8), .STOP_ON_FAIL(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .vec_valid(vec_valid[0]), .vec(vec[0]),
    .vec_ready(vec_ready[0]), .dut_d(dut_d[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .pass_cnt(pass_cnt[0]), .fail_cnt(fail_cnt[0]), .covered(covered[0]),
    .first_fail_vec(ff_vec[0]), .first_fail_vld(ff_vld[0]));

  nor3_response_checker #(.SETTLE_CYCLES(3), .CNT_W(8), .STOP_ON_FAIL(0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .vec_valid(vec_valid[1]), .vec(vec[1]),
    .vec_ready(vec_ready[1]), .dut_d(dut_d[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .pass_cnt(pass_cnt[1]), .fail_cnt(fail_cnt[1]), .covered(covered[1]),
    .first_fail_vec(ff_vec[1]), .first_fail_vld(ff_vld[1]));

  nor3_response_checker #(.SETTLE_CYCLES(0), .CNT_W(8), .STOP_ON_FAIL(1)) u_dut2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .vec_valid(vec_valid[2]), .vec(vec[2]),
    .vec_ready(vec_ready[2]), .dut_d(dut_d[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .pass_cnt(pass_cnt[2]), .fail_cnt(fail_cnt[2]), .covered(covered[2]),
    .first_fail_vec(ff_vec[2]), .first_fail_vld(ff_vld[2]));

  nor3_response_checker #(.SETTLE_CYCLES(1), .CNT_W(2), .STOP_ON_FAIL(0)) u_dut3 (
    .clk(clk), .rst(rst[3]), .start(start[3]), .vec_valid(vec_valid[3]), .vec(vec[3]),
    .vec_ready(vec_ready[3]), .dut_d(dut_d[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
    .pass_cnt(pc3), .fail_cnt(fc3), .covered(covered[3]),
    .first_fail_vec(ff_vec[3]), .first_fail_vld(ff_vld[3]));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference scoreboard per instance, derived from the run rules.
  int         m_pass[N], m_fail[N];
  logic [7:0] m_cov[N];
  logic [2:0] m_ffv[N];
  bit         m_ffvld[N], m_done[N], m_run[N];

  function automatic int settle_of(int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int max_of(int i);
    return (i == 3) ? 3 : 255;
  endfunction

  task automatic chk_eq(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_clear(int i, bit run);
    m_pass[i] = 0; m_fail[i] = 0; m_cov[i] = 8'h00; m_ffv[i] = 3'd0;
    m_ffvld[i] = 0; m_done[i] = 0; m_run[i] = run;
  endtask

  task automatic check_all(int i, string tag);
    bit exp_done;
    exp_done = m_run[i] && m_done[i];
    chk_eq($sformatf("%s[%0d].pass_cnt", tag, i), int'(pass_cnt[i]), m_pass[i]);
    chk_eq($sformatf("%s[%0d].fail_cnt", tag, i), int'(fail_cnt[i]), m_fail[i]);
    chk_eq($sformatf("%s[%0d].covered", tag, i), int'(covered[i]), int'(m_cov[i]));
    chk_eq($sformatf("%s[%0d].ff_vld", tag, i), int'(ff_vld[i]), int'(m_ffvld[i]));
    chk_eq($sformatf("%s[%0d].ff_vec", tag, i), int'(ff_vec[i]), int'(m_ffv[i]));
    chk_eq($sformatf("%s[%0d].done", tag, i), int'(done[i]), int'(exp_done));
    chk_eq($sformatf("%s[%0d].busy", tag, i), int'(busy[i]), int'(m_run[i] && !m_done[i]));
    chk_eq($sformatf("%s[%0d].vec_ready", tag, i), int'(vec_ready[i]), int'(m_run[i] && !m_done[i]));
    chk_eq($sformatf("%s[%0d].pass", tag, i), int'(pass[i]),
           int'(exp_done && m_fail[i] == 0 && m_cov[i] == 8'hFF));
  endtask

  task automatic do_start(int i);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    model_clear(i, 1);
    check_all(i, "start");
  endtask

  task automatic wait_ready(int i, output bit ok);
    for (int w = 0; w < 50 && !vec_ready[i]; w++) begin
      @(posedge clk); #1;
    end
    ok = vec_ready[i];
    if (!ok) chk_eq($sformatf("ready_timeout[%0d]", i), 0, 1);
  endtask

  // Present one vector with DUT response d; check hold-off window and final state.
  task automatic send(int i, logic [2:0] v, logic d, bit mid_start);
    bit ok;
    bit match;
    int s;
    s = settle_of(i);
    repeat ($urandom_range(0, 2)) begin
      vec_valid[i] = 1'b0;
      vec[i] = 3'($urandom);
      @(posedge clk); #1;
    end
    wait_ready(i, ok);
    if (!ok) return;
    vec_valid[i] = 1'b1;
    vec[i] = v;
    dut_d[i] = d;
    @(posedge clk); #1;
    vec_valid[i] = 1'b0;
    for (int k = 0; k <= s; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      start[i] = mid_start && (k == 0);
      chk_eq($sformatf("holdoff_ready[%0d]", i), int'(vec_ready[i]), 0);
      chk_eq($sformatf("holdoff_pass[%0d]", i), int'(pass_cnt[i]), m_pass[i]);
      chk_eq($sformatf("holdoff_fail[%0d]", i), int'(fail_cnt[i]), m_fail[i]);
    end
    @(posedge clk); #1;
    start[i] = 1'b0;
    match = (d == (v == 3'd0));
    if (match) m_pass[i] = (m_pass[i] < max_of(i)) ? m_pass[i] + 1 : m_pass[i];
    else       m_fail[i] = (m_fail[i] < max_of(i)) ? m_fail[i] + 1 : m_fail[i];
    m_cov[i] = m_cov[i] | (8'd1 << v);
    if (!match && !m_ffvld[i]) begin
      m_ffvld[i] = 1;
      m_ffv[i] = v;
    end
    if (m_cov[i] == 8'hFF || (i == 2 && !match)) m_done[i] = 1;
    check_all(i, "sample");
  endtask

  task automatic run_shuffled(int i);
    logic [2:0] order[8];
    logic [2:0] tmp;
    int j;
    for (int k = 0; k < 8; k++) order[k] = 3'(k);
    for (int k = 7; k > 0; k--) begin
      j = $urandom_range(0, k);
      tmp = order[k]; order[k] = order[j]; order[j] = tmp;
    end
    do_start(i);
    for (int k = 0; k < 8; k++) send(i, order[k], order[k] == 3'd0, 1'b0);
  endtask

  task automatic run_random(int i);
    logic [2:0] v;
    logic d;
    int n;
    n = 0;
    do_start(i);
    while (!m_done[i] && n < 200) begin
      v = 3'($urandom_range(0, 7));
      d = (v == 3'd0);
      if ($urandom_range(0, 7) == 0) d = ~d;
      send(i, v, d, $urandom_range(0, 3) == 0);
      n++;
    end
    chk_eq($sformatf("random_done[%0d]", i), int'(done[i]), 1);
  endtask

  initial begin
    bit ok;
    rst = '1; start = '0; vec_valid = '0; vec = '0; dut_d = '0;
    repeat (2) @(posedge clk);
    #1 rst = '0;
    for (int i = 0; i < N; i++) begin
      model_clear(i, 0);
      check_all(i, "reset");
    end

    // Full correct pass, in order.
    do_start(0);
    for (int v = 0; v < 8; v++) send(0, 3'(v), v == 0, 1'b0);

    // Response stuck at 0: only vector 0 mismatches.
    do_start(0);
    for (int v = 0; v < 8; v++) send(0, 3'(v), 1'b0, 1'b0);

    // Repeats of vector 2 with start pulsed mid-run.
    do_start(0);
    for (int k = 0; k < 3; k++) send(0, 3'd2, 1'b0, 1'b1);
    for (int v = 0; v < 8; v++) if (v != 2) send(0, 3'(v), v == 0, 1'b1);

    // Reset during settle aborts the run.
    do_start(0);
    wait_ready(0, ok);
    vec_valid[0] = 1'b1; vec[0] = 3'd4; dut_d[0] = 1'b0;
    @(posedge clk); #1;
    vec_valid[0] = 1'b0;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    model_clear(0, 0);
    check_all(0, "midrst");
    run_shuffled(0);

    // Longer settle window.
    run_shuffled(1);

    // Stop on first failure: vector 5 with a wrong response as the third vector.
    do_start(2);
    send(2, 3'd1, 1'b0, 1'b0);
    send(2, 3'd3, 1'b0, 1'b0);
    send(2, 3'd5, 1'b1, 1'b0);
    chk_eq("stop_cov_bits", $countones(covered[2]), 3);
    vec_valid[2] = 1'b1; vec[2] = 3'd6;
    repeat (3) @(posedge clk);
    #1 vec_valid[2] = 1'b0;
    check_all(2, "done_hold");

    // Narrow counters saturate.
    do_start(3);
    for (int k = 0; k < 5; k++) send(3, 3'd2, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send(3, 3'd0, 1'b0, 1'b0);
    for (int v = 1; v < 8; v++) if (v != 2) send(3, 3'(v), 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) run_random(i);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
